// File: rtl/instruction_fetch_queue.sv
// Instruction fetch queue: issues sequential reads (one outstanding), buffers
// returned words with their PCs and hands them to decode over valid/ready.
`timescale 1ns/1ps
module instruction_fetch_queue #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 32,
  parameter int RESET_PC     = 0,
  parameter int QUEUE_DEPTH  = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    redirect,
  input  logic [ADDRESS_BITS-1:0] redirect_pc,
  output logic                    mem_read,
  output logic [ADDRESS_BITS-1:0] mem_address,
  input  logic                    mem_ready,
  input  logic                    mem_valid,
  input  logic [DATA_WIDTH-1:0]   mem_data,
  output logic                    inst_valid,
  output logic [DATA_WIDTH-1:0]   inst,
  output logic [ADDRESS_BITS-1:0] inst_pc,
  input  logic                    inst_ready
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int PTR_W     = $clog2(QUEUE_DEPTH);
  localparam int CNT_W     = PTR_W + 1;

  logic [ADDRESS_BITS-1:0] fetch_pc_reg;
  logic                    pending_reg;
  logic [ADDRESS_BITS-1:0] pending_pc_reg;
  logic                    squash_reg;
  logic [PTR_W-1:0]        rd_ptr_reg;
  logic [PTR_W-1:0]        wr_ptr_reg;
  logic [CNT_W-1:0]        count_reg;

  logic [DATA_WIDTH-1:0]   data_mem [QUEUE_DEPTH];
  logic [ADDRESS_BITS-1:0] pc_mem   [QUEUE_DEPTH];

  logic                    pop;
  logic                    push;
  logic                    issue;
  logic [CNT_W:0]          occupancy_next;

  always_comb begin
    pop            = inst_valid & inst_ready & ~redirect;
    push           = pending_reg & mem_valid & ~squash_reg & ~redirect;
    occupancy_next = {1'b0, count_reg} + {{CNT_W{1'b0}}, push} - {{CNT_W{1'b0}}, pop};
    // A new read may go out only once the previous one has returned (or returns now).
    issue          = reset & mem_ready & ~redirect & (~pending_reg | mem_valid) &
                     (occupancy_next < (CNT_W+1)'(QUEUE_DEPTH));
  end

  assign mem_read    = issue;
  assign mem_address = fetch_pc_reg;
  assign inst_valid  = reset & (count_reg != '0);
  assign inst        = reset ? data_mem[rd_ptr_reg] : '0;
  assign inst_pc     = reset ? pc_mem[rd_ptr_reg]   : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_reg   <= ADDRESS_BITS'(RESET_PC);
      pending_reg    <= 1'b0;
      pending_pc_reg <= '0;
      squash_reg     <= 1'b0;
      rd_ptr_reg     <= '0;
      wr_ptr_reg     <= '0;
      count_reg      <= '0;
    end else if (redirect) begin
      fetch_pc_reg <= redirect_pc;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      if (pending_reg) begin
        // An in-flight read still owes a response; mark it so it is dropped later.
        if (mem_valid) begin
          pending_reg <= 1'b0;
          squash_reg  <= 1'b0;
        end else begin
          squash_reg <= 1'b1;
        end
      end
    end else begin
      if (issue) begin
        pending_reg    <= 1'b1;
        pending_pc_reg <= fetch_pc_reg;
        fetch_pc_reg   <= fetch_pc_reg + ADDRESS_BITS'(NUM_BYTES);
        if (mem_valid) squash_reg <= 1'b0;
      end else if (pending_reg && mem_valid) begin
        pending_reg <= 1'b0;
        squash_reg  <= 1'b0;
      end
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (push && !pop)      count_reg <= count_reg + CNT_W'(1);
      else if (pop && !push) count_reg <= count_reg - CNT_W'(1);
    end
  end

  // Queue storage carries no reset; entries are only observed once counted valid.
  always_ff @(posedge clock) begin
    if (push) begin
      data_mem[wr_ptr_reg] <= mem_data;
      pc_mem[wr_ptr_reg]   <= pending_pc_reg;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Bench for instruction_fetch_queue: behavioural memory with variable latency and
// a PC/data scoreboard filled on every fetch restart.
`timescale 1ns/1ps
module tb_instruction_fetch_queue;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_read;
  logic [31:0] mem_address;
  logic        mem_ready = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_data = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;

  instruction_fetch_queue #(
    .DATA_WIDTH(32), .ADDRESS_BITS(32), .RESET_PC(0), .QUEUE_DEPTH(4)
  ) dut (
    .clock(clock), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_read(mem_read), .mem_address(mem_address), .mem_ready(mem_ready),
    .mem_valid(mem_valid), .mem_data(mem_data), .inst_valid(inst_valid),
    .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
  );

  always #5 clock = ~clock;

  int          total = 0;
  int          bad = 0;
  logic [31:0] sb [$];
  logic [31:0] exp_fetch = '0;
  int          latency = 1;
  int          lat_cnt = 0;
  logic [31:0] resp_addr = '0;
  logic        req_seen = 1'b0;
  logic [31:0] req_addr = '0;
  int          cyc = 0;
  int          issue_count = 0;
  int          pop_count = 0;
  int          first_issue = -1;
  int          first_valid = -1;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h5a5a_0f0f;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic restart_sb(input logic [31:0] start);
    sb.delete();
    for (int i = 0; i < 64; i++) sb.push_back(start + 32'(4 * i));
    exp_fetch = start;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    restart_sb(pc);
    tick(1);
    redirect = 1'b0;
  endtask

  always @(posedge clock) cyc++;

  // Memory: a request seen before an edge returns data `latency` cycles later.
  always @(posedge clock) begin
    #1;
    mem_valid = 1'b0;
    if (req_seen) begin
      lat_cnt   = latency;
      resp_addr = req_addr;
    end
    if (lat_cnt > 0) begin
      lat_cnt--;
      if (lat_cnt == 0) begin
        mem_valid = 1'b1;
        mem_data  = word_of(resp_addr);
      end
    end
  end

  always @(negedge clock) begin
    logic [31:0] exp_pc;
    req_seen = mem_read;
    req_addr = mem_address;
    if (reset && redirect) check("no_issue_on_redirect", 32'(mem_read), 32'd0);
    if (reset && !redirect) begin
      if (mem_read) begin
        check("mem_addr", mem_address, exp_fetch);
        exp_fetch += 32'd4;
        issue_count++;
        if (first_issue < 0) first_issue = cyc;
      end
      if (inst_valid && first_valid < 0) first_valid = cyc;
      if (inst_valid && inst_ready) begin
        exp_pc = (sb.size() > 0) ? sb.pop_front() : 32'hffff_ffff;
        $display("pop pc=%h inst=%h", inst_pc, inst);
        check("inst_pc", inst_pc, exp_pc);
        check("inst_data", inst, word_of(exp_pc));
        pop_count++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int n0;
    logic found;
    logic [31:0] held;

    // Reset state, with mem_ready high to prove the request is gated.
    mem_ready = 1'b1;
    inst_ready = 1'b1;
    restart_sb(32'd0);
    tick(3);
    @(negedge clock);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);

    // Sequential streaming, 1-cycle memory.
    @(posedge clock); #1;
    first_issue = -1;
    first_valid = -1;
    reset = 1'b1;
    tick(12);
    check("first_latency", 32'(first_valid - first_issue), 32'd2);
    n0 = pop_count;
    tick(8);
    check("throughput", 32'(pop_count - n0), 32'd8);

    // Decode stalled: queue fills to exactly four entries.
    inst_ready = 1'b0;
    do_redirect(32'h200);
    n0 = issue_count;
    tick(10);
    @(negedge clock);
    check("full_issues", 32'(issue_count - n0), 32'd4);
    check("full_stall", 32'(mem_read), 32'd0);
    check("full_valid", 32'(inst_valid), 32'd1);
    @(posedge clock); #1;
    n0 = pop_count;
    inst_ready = 1'b1;
    tick(6);
    check("drain_no_gap", 32'(pop_count - n0), 32'd6);

    // Redirect with a partly filled queue.
    inst_ready = 1'b0;
    tick(4);
    @(negedge clock);
    check("pre_redir_valid", 32'(inst_valid), 32'd1);
    @(posedge clock); #1;
    do_redirect(32'h100);
    @(negedge clock);
    check("redir_empty", 32'(inst_valid), 32'd0);
    check("redir_read", 32'(mem_read), 32'd1);
    check("redir_addr", mem_address, 32'h100);
    @(posedge clock); #1;
    inst_ready = 1'b1;
    tick(10);

    // Slow memory: redirect while a read is outstanding; stale word must vanish.
    latency = 3;
    tick(8);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      if (mem_read) found = 1'b1;
    end
    check("wait_issue", 32'(found), 32'd1);
    @(posedge clock); #1;
    do_redirect(32'h40);
    n0 = pop_count;
    tick(15);
    check("slow_progress", 32'(pop_count > n0), 32'd1);

    // Memory not ready: no requests, address frozen, then resume there.
    latency = 1;
    tick(8);
    mem_ready = 1'b0;
    held = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("stall_read", 32'(mem_read), 32'd0);
      if (i == 0) held = mem_address;
      else check("stall_hold", mem_address, held);
    end
    @(posedge clock); #1;
    mem_ready = 1'b1;
    @(negedge clock);
    check("resume_read", 32'(mem_read), 32'd1);
    check("resume_addr", mem_address, held);

    // Asynchronous reset mid-stream.
    tick(3);
    inst_ready = 1'b0;
    tick(3);
    @(negedge clock);
    check("pre_reset_valid", 32'(inst_valid), 32'd1);
    @(posedge clock); #3;
    reset = 1'b0;
    restart_sb(32'd0);
    #1;
    check("async_valid", 32'(inst_valid), 32'd0);
    check("async_read", 32'(mem_read), 32'd0);
    check("async_inst", inst, 32'd0);
    check("async_pc", inst_pc, 32'd0);
    tick(2);
    inst_ready = 1'b1;
    first_issue = -1;
    first_valid = -1;
    n0 = pop_count;
    reset = 1'b1;
    tick(12);
    check("restart_latency", 32'(first_valid - first_issue), 32'd2);
    check("restart_progress", 32'(pop_count > n0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
